// File: rtl/dmem_responder_if.sv
// Data-memory port between the core (master) and dmem_responder (slave).
// Latency: dm_data_out is registered, valid one edge after dm_addr is sampled.
// Backpressure: none; every rising edge is a transfer.
interface dmem_responder_if;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_data_in;
  logic [31:0] dm_data_out;

  modport master (output dm_write, dm_addr, dm_data_in, input dm_data_out);
  modport slave  (input dm_write, dm_addr, dm_data_in, output dm_data_out);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus, with DMEM_MMIO_EN defined, an MMIO block (LED, CYCLE, TX FIFO + 8N1 UART).
// Latency: dm_data_out registered 1 edge after dm_addr; writes take effect at the sampling edge.
// Backpressure: none; TXDATA pushes into a full FIFO are dropped and raise sticky overflow.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned BAUD_DIV    = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  dmem_responder_if.slave bus,
  output logic            tx_o,
  output logic [7:0]      leds_o
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] ram_idx;
  logic          in_ram;
  logic [31:0]   rdata_d, rdata_q;
  logic          unused_addr;

  assign ram_idx         = bus.dm_addr[AW+1:2];
  assign in_ram          = (bus.dm_addr[31:AW+2] == '0);
  assign unused_addr     = ^bus.dm_addr[1:0];
  assign bus.dm_data_out = rdata_q;

  // RAM write port; contents intentionally survive reset.
  always_ff @(posedge clk_i) begin
    if (bus.dm_write && in_ram) mem_q[ram_idx] <= bus.dm_data_in;
  end

`ifdef DMEM_MMIO_EN
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  logic          in_mmio;
  logic [1:0]    reg_sel;
  logic          wr_led, wr_cyc, wr_txd, wr_stat;
  logic [7:0]    led_q;
  logic [31:0]   cyc_q;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q, full, empty, push, pop, busy, baud_done;
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  assign in_mmio   = (bus.dm_addr[31:4] == MMIO_BASE[31:4]) && !in_ram;
  assign reg_sel   = bus.dm_addr[3:2];
  assign wr_led    = bus.dm_write && in_mmio && (reg_sel == 2'd0);
  assign wr_cyc    = bus.dm_write && in_mmio && (reg_sel == 2'd1);
  assign wr_txd    = bus.dm_write && in_mmio && (reg_sel == 2'd2);
  assign wr_stat   = bus.dm_write && in_mmio && (reg_sel == 2'd3);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  // Full is judged on the pre-edge count, so a same-edge pop cannot rescue a push.
  assign push      = wr_txd && !full;
  assign busy      = (state_q != IDLE);
  assign baud_done = (baud_q == BW'(BAUD_DIV - 1));
  assign leds_o    = led_q;

  // LED register and free-running cycle counter (a write forces the next value to 0).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led_q <= '0;
      cyc_q <= '0;
    end else begin
      if (wr_led) led_q <= bus.dm_data_in[7:0];
      cyc_q <= wr_cyc ? 32'd0 : cyc_q + 32'd1;
    end
  end

  // FIFO storage; payload needs no reset since occupancy gates it.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= bus.dm_data_in[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (wr_txd && full) ovf_q <= 1'b1;
      else if (wr_stat)   ovf_q <= 1'b0;
    end
  end

  // Transmitter state register; reset abandons any frame in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Transmitter next state: IDLE pops a byte, then start, 8 data bits LSB first, stop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
    endcase
  end

  // Serial line level follows the state directly so reset forces idle-high at once.
  always_comb begin
    case (state_q)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift_q[0];
      default: tx_o = 1'b1;
    endcase
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{MMIO_BASE, 32'(FIFO_DEPTH), 32'(BAUD_DIV)};
  assign tx_o       = 1'b1;
  assign leds_o     = '0;
`endif

  // Read mux: RAM is write-first; MMIO reads return the pre-edge register value.
  always_comb begin
    rdata_d = '0;
    if (in_ram) begin
      rdata_d = bus.dm_write ? bus.dm_data_in : mem_q[ram_idx];
    end
`ifdef DMEM_MMIO_EN
    else if (in_mmio) begin
      case (reg_sel)
        2'd0:    rdata_d = {24'd0, led_q};
        2'd1:    rdata_d = cyc_q;
        2'd2:    rdata_d = '0;
        default: rdata_d = {23'd0, 5'(count_q), ovf_q, busy, empty, full};
      endcase
    end
`endif
  end

  // Registered read port; updates on every edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a queue-based model.
// Latency: each access is checked 1 clock after its sampling edge.
// Backpressure: none; the model tracks FIFO occupancy and drop/overflow itself.
module tb_dmem_responder;
  localparam int unsigned DW = 64;
  localparam logic [31:0] MB = 32'hFFFF_0000;
  localparam int unsigned FD = 8;
  localparam int unsigned BD = 4;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx;
  logic [7:0] leds;

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH_WORDS(DW), .MMIO_BASE(MB), .FIFO_DEPTH(FD), .BAUD_DIV(BD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .tx_o(tx), .leds_o(leds)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] ram_m [DW];
  logic [7:0]  led_m;
  logic [31:0] cyc_m;
  logic [7:0]  q_m [$];
  bit          ovf_m;
  int          tx_rem;
  logic [7:0]  cur_m;
  logic [31:0] exp_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'(DW * 4);
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return MMIO_ON && (a >= MB) && (a < MB + 32'd16);
  endfunction

  // Line level from the position inside the current 10-slot frame.
  function automatic logic exp_tx();
    int slot;
    if (tx_rem == 0) return 1'b1;
    slot = (10 * BD - tx_rem) / BD;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return cur_m[slot-1];
  endfunction

  task automatic model_reset();
    led_m  = 8'd0;
    cyc_m  = 32'd0;
    q_m.delete();
    ovf_m  = 1'b0;
    tx_rem = 0;
  endtask

  task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d);
    int off;
    bit full;
    bit pop;
    off  = int'((a - MB) >> 2);
    full = (q_m.size() == FD);
    exp_dout = 32'd0;
    if (is_ram(a)) begin
      exp_dout = we ? d : ram_m[int'(a >> 2)];
      if (we) ram_m[int'(a >> 2)] = d;
    end else if (is_mmio(a)) begin
      case (off)
        0: exp_dout = {24'd0, led_m};
        1: exp_dout = cyc_m;
        2: exp_dout = 32'd0;
        default: exp_dout = 32'((full ? 1 : 0) + (q_m.size() == 0 ? 2 : 0) +
                                (tx_rem != 0 ? 4 : 0) + (ovf_m ? 8 : 0) + q_m.size() * 16);
      endcase
    end
    pop = (tx_rem == 0) && (q_m.size() != 0);
    if (tx_rem > 0) tx_rem--;
    if (pop) begin
      cur_m  = q_m.pop_front();
      tx_rem = 10 * BD;
    end
    cyc_m = (we && is_mmio(a) && off == 1) ? 32'd0 : cyc_m + 32'd1;
    if (we && is_mmio(a)) begin
      case (off)
        0: led_m = d[7:0];
        2: if (full) ovf_m = 1'b1; else q_m.push_back(d[7:0]);
        3: ovf_m = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic do_cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.dm_write   = we;
    bus.dm_addr    = a;
    bus.dm_data_in = d;
    @(posedge clk);
    model_step(we, a, d);
    #1;
    check("dout", bus.dm_data_out, exp_dout);
    check("leds", {24'd0, leds}, MMIO_ON ? {24'd0, led_m} : 32'd0);
    check("tx", {31'd0, tx}, MMIO_ON ? {31'd0, exp_tx()} : 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    int          r;
    logic [9:0]  pat;

    rst_n          = 1'b0;
    bus.dm_write   = 1'b0;
    bus.dm_addr    = 32'd0;
    bus.dm_data_in = 32'd0;
    model_reset();
    #22;
    check("rst_dout", bus.dm_data_out, 32'd0);
    check("rst_leds", {24'd0, leds}, 32'd0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    rst_n = 1'b1;

    // Give every RAM word a known value
    for (int i = 0; i < DW; i++) do_cycle(1'b1, 32'(i * 4), $urandom);

    // RAM read-back, ignoring byte offset
    do_cycle(1'b1, 32'h10, 32'hDEADBEEF);
    do_cycle(1'b0, 32'h10, 32'd0);
    check("ram_rd", bus.dm_data_out, 32'hDEADBEEF);
    do_cycle(1'b0, 32'h13, 32'd0);
    check("ram_rd_0x13", bus.dm_data_out, 32'hDEADBEEF);

    // Unmapped write is dropped
    do_cycle(1'b1, 32'h8000_0000, 32'h1234);
    do_cycle(1'b0, 32'h8000_0000, 32'd0);
    check("unmapped_rd", bus.dm_data_out, 32'd0);
    do_cycle(1'b0, 32'h0, 32'd0);

    // LED register
    do_cycle(1'b1, MB, 32'h1A5);
    check("led_out", {24'd0, leds}, MMIO_ON ? 32'hA5 : 32'd0);
    do_cycle(1'b0, MB, 32'd0);
    check("led_rd", bus.dm_data_out, MMIO_ON ? 32'hA5 : 32'd0);

    // Single frame of 0x55: slot k level is k odd
    pat = 10'h2AA;
    do_cycle(1'b1, MB + 32'd8, 32'h55);
    for (int i = 0; i < 44; i++) begin
      do_cycle(1'b0, MB + 32'd12, 32'd0);
      if (i < 40 && (i % 4) == 2) check("tx_55", {31'd0, tx}, MMIO_ON ? {31'd0, pat[i/4]} : 32'd1);
      if (i == 20) check("busy_mid", bus.dm_data_out & 32'd4, MMIO_ON ? 32'd4 : 32'd0);
    end
    check("busy_after", bus.dm_data_out & 32'd4, 32'd0);

    // Overrun the FIFO with 10 back-to-back pushes
    for (int i = 0; i < 10; i++) do_cycle(1'b1, MB + 32'd8, 32'(8'h30 + i));
    do_cycle(1'b0, MB + 32'd12, 32'd0);
    check("stat_full_ovf", bus.dm_data_out & 32'd9, MMIO_ON ? 32'd9 : 32'd0);
    for (int i = 0; i < 380; i++) do_cycle(1'b0, MB + 32'd12, 32'd0);
    do_cycle(1'b1, MB + 32'd12, 32'd0);
    do_cycle(1'b0, MB + 32'd12, 32'd0);
    check("ovf_clear", bus.dm_data_out & 32'd8, 32'd0);

    // CYCLE: write, read five edges later
    do_cycle(1'b1, MB + 32'd4, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 32'h20, 32'd0);
    do_cycle(1'b0, MB + 32'd4, 32'd0);
    check("cycle_rd", bus.dm_data_out, MMIO_ON ? 32'd4 : 32'd0);

    // Random traffic over RAM, unmapped space and the MMIO window
    for (int i = 0; i < 2000; i++) begin
      r  = int'($urandom_range(0, 9));
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      if (r < 5)      a = $urandom_range(0, DW * 4 - 1);
      else if (r < 6) a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
      else            a = MB + $urandom_range(0, 15);
      do_cycle(we, a, d);
    end

    // Drain whatever is left, bounded
    for (int i = 0; i < 2000 && (q_m.size() != 0 || tx_rem != 0); i++)
      do_cycle(1'b0, MB + 32'd12, 32'd0);
    do_cycle(1'b0, MB + 32'd12, 32'd0);
    check("drained", bus.dm_data_out & 32'h1F7, MMIO_ON ? 32'd2 : 32'd0);

    // Asynchronous reset in the middle of a frame
    do_cycle(1'b1, MB, 32'h3C);
    do_cycle(1'b1, MB + 32'd8, 32'hC3);
    for (int i = 0; i < 15; i++) do_cycle(1'b0, 32'h40, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_leds", {24'd0, leds}, 32'd0);
    check("arst_tx", {31'd0, tx}, 32'd1);
    check("arst_dout", bus.dm_data_out, 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    do_cycle(1'b0, MB + 32'd4, 32'd0);
    check("cyc_first_edge", bus.dm_data_out, 32'd0);
    do_cycle(1'b0, MB + 32'd4, 32'd0);
    check("cyc_second_edge", bus.dm_data_out, MMIO_ON ? 32'd1 : 32'd0);
    do_cycle(1'b0, MB + 32'd12, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
